// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - multi-cycle sliced adder controller with valid/ready handshakes
//
// Computes s = x + y + cin (unsigned, WIDTH bits, plus carry out) by running one
// SLICE-bit adder over N = WIDTH/SLICE cycles, least significant slice first.
// Optional feature macro: ADD_SEQ_OVF_EN adds a registered signed-overflow output.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand request (sampled only in IDLE)
//   in_ready   controller idle and able to accept operands
//   x, y, cin  operands and carry in (latched at the accept edge)
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result (sampled only in DONE)
//   s, cout    registered sum and carry out
//   ovf        registered signed overflow (ADD_SEQ_OVF_EN only)
//   busy       high in RUN or DONE
module add_seq_ctrl #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef ADD_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [WIDTH-1:0] xReg;
    logic [WIDTH-1:0] yReg;
    logic             carry;
    logic [CNT_W-1:0] sliceCnt;
    logic             lastSlice;
    logic [SLICE-1:0] xSlice;
    logic [SLICE-1:0] ySlice;
    logic [SLICE:0]   sliceSum;

    assign lastSlice = (sliceCnt == LAST_CNT);
    assign xSlice    = xReg[int'(sliceCnt) * SLICE +: SLICE];
    assign ySlice    = yReg[int'(sliceCnt) * SLICE +: SLICE];
    // The top bit of the widened sum is the carry into the next slice.
    assign sliceSum  = {1'b0, xSlice} + {1'b0, ySlice} + {{SLICE{1'b0}}, carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (lastSlice) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xReg     <= '0;
            yReg     <= '0;
            carry    <= 1'b0;
            sliceCnt <= '0;
            s        <= '0;
            cout     <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                xReg     <= x;
                yReg     <= y;
                carry    <= cin;
                sliceCnt <= '0;
                s        <= '0;
            end else if (state == RUN) begin
                s[int'(sliceCnt) * SLICE +: SLICE] <= sliceSum[SLICE-1:0];
                carry <= sliceSum[SLICE];
                // Park the counter at zero after the last slice so the slice
                // select never points past the operand registers.
                sliceCnt <= lastSlice ? '0 : sliceCnt + 1'b1;
                if (lastSlice) begin
                    cout <= sliceSum[SLICE];
`ifdef ADD_SEQ_OVF_EN
                    // Final slice holds the sign bit of the result.
                    ovf  <= (xReg[WIDTH-1] == yReg[WIDTH-1]) &&
                            (sliceSum[SLICE-1] != xReg[WIDTH-1]);
`endif
                end
            end
        end
    end

endmodule
